elevator_ctrl: RTL and testbench
================================

Name: elevator_ctrl

Overview:
- Control FSM for the elevator. It consumes the floor/request flags produced by the elevator datapath and drives the datapath's open, up and down strobes.
- Implements SCAN scheduling: keep moving in the current direction while requests remain ahead, then reverse.
- Adds per-floor travel timing, a door dwell timer with a hold input, and end-of-shaft protection.

Parameters:
- TRAVEL_CYCLES, 8, clock cycles spent moving between adjacent floors (>=2).
- DOOR_CYCLES, 16, clock cycles the door stays open (>=2).
- TW, 5, timer width; must hold max(TRAVEL_CYCLES, DOOR_CYCLES)-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- request_i  input  1  pending request at the current floor.
- request_j_gt_i  input  1  pending request above the current floor.
- request_j_lt_i  input  1  pending request below the current floor.
- at_top  input  1  car is at floor n-1 (datapath i[n-1]).
- at_bottom  input  1  car is at floor 0 (datapath i[0]).
- door_hold  input  1  door-open button / obstruction, level.
- open  output  1  clear request at the current floor; asserted for the whole DOOR state.
- up  output  1  one-cycle strobe: datapath shifts floor up.
- down  output  1  one-cycle strobe: datapath shifts floor down.
- door_open  output  1  door actuator, level.
- dir_up  output  1  remembered travel direction (1 = up).
- state  output  3  current FSM state code, for debug.

Behaviour:
- Reset (asynchronous, active-high, any state): state=IDLE (0), timer=0, dir_up=1. All outputs are 0 except dir_up=1.
- State codes: IDLE=0, MOVE_UP=1, MOVE_DN=2, SETTLE=3, DOOR=4, ESTOP=5.
- Decision function D (used in IDLE and SETTLE). Priority, highest first:
  - request_i: go to DOOR.
  - A request ahead in dir_up direction: move that way.
  - A request in the opposite direction: flip dir_up, then move.
  - No requests: IDLE.
- IDLE: evaluate D every cycle; stay in IDLE while no request. dir_up is kept.
- MOVE_UP / MOVE_DN:
  - On entry, timer=0; it increments each cycle.
  - In the cycle where timer==TRAVEL_CYCLES-1, assert up (or down) for exactly that cycle, then go to SETTLE.
  - Travel latency is TRAVEL_CYCLES cycles per floor.
- SETTLE:
  - Single cycle that lets the datapath's floor register and flags update after the strobe.
  - Evaluate D on the updated flags.
  - Next state is never a move without passing through SETTLE first.
- Shaft-end guard:
  - MOVE_UP is never entered when at_top=1; MOVE_DN is never entered when at_bottom=1.
  - If D would choose a blocked direction, treat that direction as having no request.
  - up is never asserted while at_top=1; down is never asserted while at_bottom=1.
- DOOR:
  - door_open=1 and open=1 every cycle, so new presses at this floor are absorbed.
  - On entry, timer=0; it increments each cycle.
  - door_hold=1 forces timer=0 that cycle.
  - When timer==DOOR_CYCLES-1 and door_hold=0, go to SETTLE.
  - Minimum dwell is DOOR_CYCLES cycles.
- Simultaneous events:
  - request_i together with a request ahead: door first.
  - door_hold held indefinitely: door stays open indefinitely.
  - Requests arriving during MOVE do not abort the move; they are considered at SETTLE.
- up and down are mutually exclusive. Neither is asserted in DOOR, IDLE or SETTLE.
- Reset mid-move: any pending strobe is dropped, and the datapath floor register is reset by the shared reset.

Optional Feature:
- Macro: ELEVATOR_ESTOP_EN.
- Defined:
  - Adds input port estop (1 bit, level).
  - estop=1 in any state: next state is ESTOP, with up=down=0 and open=0.
  - door_open=1 in ESTOP only if the car was in DOOR on entry.
  - ESTOP holds while estop=1. On release, go to SETTLE with timer=0.
  - estop has priority over all transitions, including an up/down strobe in the same cycle; the strobe is suppressed.
- Undefined: no estop port, and state 5 is unreachable.

Test Plan (TRAVEL_CYCLES=4, DOOR_CYCLES=6):
- Reset: car at floor 0, no requests → IDLE, all outputs 0, dir_up=1, state=0 held for 20 cycles.
- Floor-3 request from floor 0:
  - Exactly 3 up pulses, each 5 cycles apart (4 MOVE + 1 SETTLE), and no down pulse.
  - Then DOOR: door_open=1 for 6 cycles, then SETTLE, then IDLE.
- Request at the current floor while IDLE → DOOR entered the next cycle; open=1 for 6 cycles.
- door_hold pulsed at DOOR cycle 4 → door_open stays high for 4+6=10 cycles total.
- SCAN order: car at floor 2 moving up, requests at floors 5 and 0 → services floor 5 first, then dir_up becomes 0 and it travels down to floor 0 with 5 down pulses.
- At floor n-1, force request_j_gt_i=1 → up never asserted and no MOVE_UP entry; with ELEVATOR_ESTOP_EN, estop=1 mid-MOVE_UP at timer=3 → no up pulse, state=5; on release → SETTLE.

Source files
------------

// File: rtl/elevator_ctrl.sv
// SCAN elevator control FSM: per-floor travel timer, door dwell with hold, shaft-end guard.
// Optional emergency stop input enabled by defining ELEVATOR_ESTOP_EN.
module elevator_ctrl #(
    parameter int TRAVEL_CYCLES = 8,
    parameter int DOOR_CYCLES   = 16,
    parameter int TW            = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       request_i,
    input  logic       request_j_gt_i,
    input  logic       request_j_lt_i,
    input  logic       at_top,
    input  logic       at_bottom,
    input  logic       door_hold,
`ifdef ELEVATOR_ESTOP_EN
    input  logic       estop,
`endif
    output logic       open,
    output logic       up,
    output logic       down,
    output logic       door_open,
    output logic       dir_up,
    output logic [2:0] state
);

    // state     | meaning
    // IDLE      | no pending requests, waiting
    // MOVE_UP   | travelling up one floor, up strobe on last timer cycle
    // MOVE_DN   | travelling down one floor, down strobe on last timer cycle
    // SETTLE    | one cycle for datapath flags to update, then decide
    // DOOR      | door open, request at this floor being cleared
    // ESTOP     | emergency stop held
    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_MOVE_UP = 3'd1,
        S_MOVE_DN = 3'd2,
        S_SETTLE  = 3'd3,
        S_DOOR    = 3'd4,
        S_ESTOP   = 3'd5
    } state_t;

    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [TW-1:0] TRAVEL_PRE  = TW'(TRAVEL_CYCLES - 2);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_CYCLES - 1);

    state_t        state_r;
    logic [TW-1:0] timer;
    logic          dir_up_r;
    logic          up_q;
    logic          dn_q;
    logic          estop_act;

`ifdef ELEVATOR_ESTOP_EN
    assign estop_act = estop;
`else
    assign estop_act = 1'b0;
`endif

    // A request beyond the shaft end is treated as absent.
    logic   req_up_ok;
    logic   req_dn_ok;
    logic   ahead;
    logic   behind;
    state_t dec_state;
    logic   dec_dir;

    assign req_up_ok = request_j_gt_i & ~at_top;
    assign req_dn_ok = request_j_lt_i & ~at_bottom;
    assign ahead     = dir_up_r ? req_up_ok : req_dn_ok;
    assign behind    = dir_up_r ? req_dn_ok : req_up_ok;

    always_comb begin
        dec_state = S_IDLE;
        dec_dir   = dir_up_r;
        if (request_i) begin
            dec_state = S_DOOR;
        end else if (ahead) begin
            dec_state = dir_up_r ? S_MOVE_UP : S_MOVE_DN;
        end else if (behind) begin
            dec_dir   = ~dir_up_r;
            dec_state = dir_up_r ? S_MOVE_DN : S_MOVE_UP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            timer     <= '0;
            dir_up_r  <= 1'b1;
            open      <= 1'b0;
            door_open <= 1'b0;
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
        end else begin
            up_q      <= 1'b0;
            dn_q      <= 1'b0;
            open      <= 1'b0;
            door_open <= 1'b0;
            if (estop_act) begin
                state_r   <= S_ESTOP;
                timer     <= '0;
                // door stays open only if the stop caught the car with its door open
                door_open <= (state_r == S_ESTOP) ? door_open : (state_r == S_DOOR);
            end else begin
                case (state_r)
                    S_IDLE, S_SETTLE: begin
                        state_r   <= dec_state;
                        dir_up_r  <= dec_dir;
                        timer     <= '0;
                        open      <= (dec_state == S_DOOR);
                        door_open <= (dec_state == S_DOOR);
                    end
                    S_MOVE_UP: begin
                        if (timer == TRAVEL_LAST) begin
                            state_r <= S_SETTLE;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                            up_q  <= (timer == TRAVEL_PRE) & ~at_top;
                        end
                    end
                    S_MOVE_DN: begin
                        if (timer == TRAVEL_LAST) begin
                            state_r <= S_SETTLE;
                            timer   <= '0;
                        end else begin
                            timer <= timer + 1'b1;
                            dn_q  <= (timer == TRAVEL_PRE) & ~at_bottom;
                        end
                    end
                    S_DOOR: begin
                        if (door_hold) begin
                            timer     <= '0;
                            open      <= 1'b1;
                            door_open <= 1'b1;
                        end else if (timer == DOOR_LAST) begin
                            state_r <= S_SETTLE;
                            timer   <= '0;
                        end else begin
                            timer     <= timer + 1'b1;
                            open      <= 1'b1;
                            door_open <= 1'b1;
                        end
                    end
                    S_ESTOP: begin
                        state_r <= S_SETTLE;
                        timer   <= '0;
                    end
                    default: begin
                        state_r <= S_IDLE;
                        timer   <= '0;
                    end
                endcase
            end
        end
    end

    // Strobes are dropped combinationally so an estop or shaft-end flag wins in the same cycle.
    assign up     = up_q & ~at_top & ~estop_act;
    assign down   = dn_q & ~at_bottom & ~estop_act;
    assign dir_up = dir_up_r;
    assign state  = state_r;

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl with an 8-floor datapath model.
module tb_elevator_ctrl;
    localparam int TC = 4;
    localparam int DC = 6;
    localparam int TW = 5;
    localparam int NF = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       request_i, request_j_gt_i, request_j_lt_i, at_top, at_bottom;
    logic       door_hold;
    logic       open, up, down, door_open, dir_up;
    logic [2:0] state;
`ifdef ELEVATOR_ESTOP_EN
    logic       estop;
`endif

    elevator_ctrl #(.TRAVEL_CYCLES(TC), .DOOR_CYCLES(DC), .TW(TW)) dut (
        .clk(clk), .rst(rst),
        .request_i(request_i), .request_j_gt_i(request_j_gt_i), .request_j_lt_i(request_j_lt_i),
        .at_top(at_top), .at_bottom(at_bottom), .door_hold(door_hold),
`ifdef ELEVATOR_ESTOP_EN
        .estop(estop),
`endif
        .open(open), .up(up), .down(down), .door_open(door_open), .dir_up(dir_up), .state(state)
    );

    always #5 clk = ~clk;

    // datapath model: floor register and per-floor request bits, or direct flag override
    int          floor_n;
    logic [NF-1:0] reqs;
    logic        ovr;
    logic        o_ri, o_gt, o_lt, o_top, o_bot;

    always_comb begin
        request_i      = 1'b0;
        request_j_gt_i = 1'b0;
        request_j_lt_i = 1'b0;
        at_top         = 1'b0;
        at_bottom      = 1'b0;
        if (ovr) begin
            request_i      = o_ri;
            request_j_gt_i = o_gt;
            request_j_lt_i = o_lt;
            at_top         = o_top;
            at_bottom      = o_bot;
        end else begin
            for (int f = 0; f < NF; f++) begin
                if (reqs[f] && f == floor_n) request_i = 1'b1;
                if (reqs[f] && f > floor_n)  request_j_gt_i = 1'b1;
                if (reqs[f] && f < floor_n)  request_j_lt_i = 1'b1;
            end
            at_top    = (floor_n == NF - 1);
            at_bottom = (floor_n == 0);
        end
    end

    int errors = 0;
    int checks = 0;
    int cyc, n_up, n_dn, n_both, n_door, first_up, last_up, bad_gap;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic clr();
        cyc = 0; n_up = 0; n_dn = 0; n_both = 0; n_door = 0;
        first_up = -1; last_up = -1; bad_gap = 0;
    endtask

    // Called at a negedge: records this cycle, advances one clock, updates the model.
    task automatic step();
        logic u, d, o;
        int   f0;
        u = up; d = down; o = open; f0 = floor_n;
        if (u) begin
            if (n_up > 0 && cyc - last_up != TC + 1) bad_gap++;
            if (n_up == 0) first_up = cyc;
            last_up = cyc;
            n_up++;
        end
        if (d) n_dn++;
        if (u && d) n_both++;
        if (door_open) n_door++;
        @(posedge clk);
        #1;
        if (!ovr) begin
            if (o) reqs[f0] = 1'b0;
            if (u && floor_n < NF - 1) floor_n++;
            if (d && floor_n > 0) floor_n--;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ovr = 1'b0;
        {o_ri, o_gt, o_lt, o_top, o_bot} = '0;
        floor_n = 0;
        reqs = '0;
        door_hold = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
        estop = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int k;
        k = 0;
        while (state != 3'd0 && k < 60) begin
            step();
            k++;
        end
        check(name, int'(state), 0);
    endtask

    typedef struct {
        logic       do_rst;
        logic       ri, gt, lt, top, bot;
        logic [2:0] exp_state;
        logic       exp_dir;
    } vec_t;

    vec_t vecs[12];

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int bad, k, n, first_door, seen_mu, seen_md;
        // rst ri gt lt top bot -> state dir
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd4, 1'b1};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 1'b1};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 1'b1};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 3'd2, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 3'd4, 1'b1};

        rst = 1'b1;
        ovr = 1'b0;
        {o_ri, o_gt, o_lt, o_top, o_bot} = '0;
        floor_n = 0;
        reqs = '0;
        door_hold = 1'b0;
`ifdef ELEVATOR_ESTOP_EN
        estop = 1'b0;
`endif
        @(negedge clk);
        @(negedge clk);
        check("rst_state", int'(state), 0);
        check("rst_dir_up", int'(dir_up), 1);
        check("rst_outs", int'({open, up, down, door_open}), 0);

        rst = 1'b0;
        clr();
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (state != 3'd0 || dir_up != 1'b1 || {open, up, down, door_open} != 4'b0) bad++;
            step();
        end
        check("reset_idle_hold", bad, 0);

        // decision function from IDLE, one vector per record
        for (int i = 0; i < 12; i++) begin
            if (vecs[i].do_rst) do_reset();
            ovr = 1'b1;
            {o_ri, o_gt, o_lt, o_top, o_bot} =
                {vecs[i].ri, vecs[i].gt, vecs[i].lt, vecs[i].top, vecs[i].bot};
            step();
            check($sformatf("vec%0d_state", i), int'(state), int'(vecs[i].exp_state));
            check($sformatf("vec%0d_dir", i), int'(dir_up), int'(vecs[i].exp_dir));
            check($sformatf("vec%0d_strobe", i), int'({up, down}), 0);
            {o_ri, o_gt, o_lt, o_top, o_bot} = '0;
            wait_idle($sformatf("vec%0d_idle", i));
        end

        // floor 0 to floor 3
        do_reset();
        clr();
        reqs[3] = 1'b1;
        for (int i = 0; i < 22; i++) step();
        check("trip_settle", int'(state), 3);
        step();
        check("trip_idle", int'(state), 0);
        check("trip_up_pulses", n_up, 3);
        check("trip_first_up", first_up, 4);
        check("trip_up_gap", bad_gap, 0);
        check("trip_down_pulses", n_dn, 0);
        check("trip_door_cycles", n_door, 6);
        check("trip_floor", floor_n, 3);

        // request at current floor while idle
        reqs[3] = 1'b1;
        step();
        check("here_door_entry", int'(state), 4);
        n = 0; k = 0;
        while (state == 3'd4 && k < 40) begin
            if (open) n++;
            step();
            k++;
        end
        check("here_open_cycles", n, 6);
        check("here_settle", int'(state), 3);
        wait_idle("here_idle");

        // door_hold pulse on door cycle 4
        reqs[3] = 1'b1;
        step();
        n = 0; k = 0;
        while (state == 3'd4 && k < 40) begin
            k++;
            if (door_open) n++;
            door_hold = (k == 4);
            step();
        end
        door_hold = 1'b0;
        check("hold_door_cycles", n, 10);
        wait_idle("hold_idle");

        // SCAN: at floor 2 going up, requests at 5 and 0
        do_reset();
        floor_n = 2;
        reqs = 8'b0010_0001;
        clr();
        first_door = -1;
        k = 0;
        while (!(reqs == '0 && state == 3'd0) && k < 300) begin
            if (state == 3'd4 && first_door < 0) first_door = floor_n;
            step();
            k++;
        end
        check("scan_done", int'(reqs == '0 && state == 3'd0), 1);
        check("scan_first_floor", first_door, 5);
        check("scan_up_pulses", n_up, 3);
        check("scan_down_pulses", n_dn, 5);
        check("scan_dir_up", int'(dir_up), 0);
        check("scan_floor", floor_n, 0);
        check("scan_both", n_both, 0);

        // async reset mid-move
        do_reset();
        ovr = 1'b1;
        o_gt = 1'b1;
        step(); step(); step(); step();
        rst = 1'b1;
        #1;
        check("rst_mid_state", int'(state), 0);
        check("rst_mid_up", int'(up), 0);
        @(negedge clk);
        rst = 1'b0;

        // shaft ends
        do_reset();
        ovr = 1'b1;
        o_gt = 1'b1; o_top = 1'b1;
        clr();
        seen_mu = 0;
        for (int i = 0; i < 20; i++) begin
            if (state == 3'd1) seen_mu++;
            step();
        end
        check("top_up_pulses", n_up, 0);
        check("top_move_up", seen_mu, 0);
        {o_gt, o_top} = 2'b00;
        o_lt = 1'b1; o_bot = 1'b1;
        clr();
        seen_md = 0;
        for (int i = 0; i < 20; i++) begin
            if (state == 3'd2) seen_md++;
            step();
        end
        check("bot_down_pulses", n_dn, 0);
        check("bot_move_dn", seen_md, 0);
        check("bot_idle", int'(state), 0);

`ifdef ELEVATOR_ESTOP_EN
        do_reset();
        ovr = 1'b1;
        o_gt = 1'b1;
        clr();
        step(); step(); step(); step();
        check("estop_pre_state", int'(state), 1);
        estop = 1'b1;
        #1;
        check("estop_strobe_gate", int'(up), 0);
        step();
        check("estop_state", int'(state), 5);
        check("estop_door", int'(door_open), 0);
        check("estop_up_pulses", n_up, 0);
        o_gt = 1'b0;
        estop = 1'b0;
        step();
        check("estop_release", int'(state), 3);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
